// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port data-memory arbiter.
package mem_arb_pkg;

    localparam int unsigned DEF_AW       = 32;
    localparam int unsigned DEF_DW       = 32;
    localparam int unsigned DEF_MAX_WAIT = 8;
    localparam int unsigned CNT_W        = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/arb_age_counter.sv
// Saturating count of consecutive cycles port 1 has been refused.
module arb_age_counter
    import mem_arb_pkg::*;
#(
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic sat
);

    logic [CNT_W-1:0] wait_cnt;

    assign sat = (wait_cnt == CNT_W'(MAX_WAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            wait_cnt <= '0;
        end else if (clr) begin
            wait_cnt <= '0;
        end else if (inc && !sat) begin
            wait_cnt <= wait_cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port arbiter in front of a single-port synchronous data RAM.
// ARB_RR_EN selects round-robin contention resolution instead of fixed priority.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int unsigned AW       = DEF_AW,
    parameter int unsigned DW       = DEF_DW,
    parameter int unsigned MAX_WAIT = DEF_MAX_WAIT
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0,
    input  logic          we0,
    input  logic          lock0,
    input  logic [AW-1:0] addr0,
    input  logic [DW-1:0] wdata0,
    output logic          gnt0,
    output logic          rvalid0,
    output logic [DW-1:0] rdata0,
    input  logic          req1,
    input  logic          we1,
    input  logic          lock1,
    input  logic [AW-1:0] addr1,
    input  logic [DW-1:0] wdata1,
    output logic          gnt1,
    output logic          rvalid1,
    output logic [DW-1:0] rdata1,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       age_sat;
    logic       sel1;
    logic       rd_valid;
    port_id_t   rd_tag;

    arb_age_counter #(
        .MAX_WAIT (MAX_WAIT)
    ) u_age (
        .clk (clk),
        .rst (rst),
        .inc (req1 & ~gnt1),
        .clr (gnt1 | ~req1),
        .sat (age_sat)
    );

`ifdef ARB_RR_EN
    port_id_t last_gnt;

    // Reset to port 1 so port 0 takes the first contended slot.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= PORT1;
        end else if (gnt0) begin
            last_gnt <= PORT0;
        end else if (gnt1) begin
            last_gnt <= PORT1;
        end
    end

    assign sel1 = (last_gnt == PORT0) || age_sat;
`else
    assign sel1 = age_sat;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Ownership ends on an unlocked grant or when the owner stops requesting.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (gnt0 && lock0) begin
                    state_nxt = OWN0;
                end else if (gnt1 && lock1) begin
                    state_nxt = OWN1;
                end
            end
            OWN0:    if (!req0 || !lock0) state_nxt = IDLE;
            OWN1:    if (!req1 || !lock1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        gnt0 = 1'b0;
        gnt1 = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (req0 && req1) begin
                        gnt1 = sel1;
                        gnt0 = ~sel1;
                    end else begin
                        gnt0 = req0;
                        gnt1 = req1;
                    end
                end
                OWN0:    gnt0 = req0;
                OWN1:    gnt1 = req1;
                default: ;
            endcase
        end

        mem_en    = gnt0 | gnt1;
        mem_we    = (gnt0 & we0) | (gnt1 & we1);
        mem_addr  = gnt1 ? addr1  : (gnt0 ? addr0  : '0);
        mem_wdata = gnt1 ? wdata1 : (gnt0 ? wdata0 : '0);
        rdata0    = rvalid0 ? mem_rdata : '0;
        rdata1    = rvalid1 ? mem_rdata : '0;
    end

    // Remember which port owns the read data returning next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_tag   <= PORT0;
        end else begin
            rd_valid <= (gnt0 & ~we0) | (gnt1 & ~we1);
            rd_tag   <= gnt1 ? PORT1 : PORT0;
        end
    end

    assign rvalid0 = rd_valid && (rd_tag == PORT0);
    assign rvalid1 = rd_valid && (rd_tag == PORT1);

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: per-cycle model comparison plus literal checks.
module tb_mem_arbiter;

    localparam int unsigned AW       = 32;
    localparam int unsigned DW       = 32;
    localparam int          MAX_WAIT = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0, we0, lock0, req1, we1, lock1;
    logic [AW-1:0] addr0, addr1;
    logic [DW-1:0] wdata0, wdata1;
    logic          gnt0, gnt1, rvalid0, rvalid1;
    logic [DW-1:0] rdata0, rdata1;
    logic          mem_en, mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    mem_arbiter #(.AW(AW), .DW(DW), .MAX_WAIT(MAX_WAIT)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .we0(we0), .lock0(lock0), .addr0(addr0), .wdata0(wdata0),
        .gnt0(gnt0), .rvalid0(rvalid0), .rdata0(rdata0),
        .req1(req1), .we1(we1), .lock1(lock1), .addr1(addr1), .wdata1(wdata1),
        .gnt1(gnt1), .rvalid1(rvalid1), .rdata1(rdata1),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    function automatic logic [DW-1:0] init_val(input logic [7:0] a);
        return (a == 8'h10) ? 32'hDEAD_BEEF : {24'hA5_0000, a};
    endfunction

    // RAM environment: 1-cycle read latency; unwritten words hold init_val.
    logic [DW-1:0] ram [256];
    bit            ram_v [256];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) begin
                ram[mem_addr[7:0]]   <= mem_wdata;
                ram_v[mem_addr[7:0]] <= 1'b1;
            end else begin
                mem_rdata <= ram_v[mem_addr[7:0]] ? ram[mem_addr[7:0]] : init_val(mem_addr[7:0]);
            end
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Model: owner (-1 none), refusal age, last winner, pending read, shadow memory.
    int            m_owner   = -1;
    int            m_age     = 0;
    int            m_last    = 1;
    int            m_rd_port = -1;
    logic [DW-1:0] m_rd_data = '0;
    logic [DW-1:0] shadow [256];
    bit            shadow_v [256];
    logic          e_g0, e_g1;

    always @(negedge clk) begin
        if (chk_en) begin
            int win;
            e_g0 = 1'b0;
            e_g1 = 1'b0;
            if (!rst) begin
                if (m_owner == 0) e_g0 = req0;
                else if (m_owner == 1) e_g1 = req1;
                else if (req0 && req1) begin
`ifdef ARB_RR_EN
                    win = (m_last == 0) ? 1 : 0;
`else
                    win = (m_age >= MAX_WAIT) ? 1 : 0;
`endif
                    e_g0 = (win == 0);
                    e_g1 = (win == 1);
                end else begin
                    e_g0 = req0;
                    e_g1 = req1;
                end
            end
            check("gnt0", gnt0, e_g0);
            check("gnt1", gnt1, e_g1);
            check("mem_en", mem_en, e_g0 | e_g1);
            check("mem_we", mem_we, (e_g0 & we0) | (e_g1 & we1));
            check("mem_addr", mem_addr, e_g1 ? addr1 : (e_g0 ? addr0 : '0));
            check("mem_wdata", mem_wdata, e_g1 ? wdata1 : (e_g0 ? wdata0 : '0));
            check("rvalid0", rvalid0, m_rd_port == 0);
            check("rvalid1", rvalid1, m_rd_port == 1);
            check("rdata0", rdata0, (m_rd_port == 0) ? m_rd_data : '0);
            check("rdata1", rdata1, (m_rd_port == 1) ? m_rd_data : '0);
        end
    end

    always @(posedge clk) begin
        if (chk_en) begin
            if (rst) begin
                m_owner = -1; m_age = 0; m_last = 1; m_rd_port = -1;
            end else begin
                logic [7:0] a;
                m_rd_port = -1;
                if (e_g0 || e_g1) begin
                    a = e_g1 ? addr1[7:0] : addr0[7:0];
                    if (e_g1 ? we1 : we0) begin
                        shadow[a]   = e_g1 ? wdata1 : wdata0;
                        shadow_v[a] = 1'b1;
                    end else begin
                        m_rd_port = e_g1 ? 1 : 0;
                        m_rd_data = shadow_v[a] ? shadow[a] : init_val(a);
                    end
                    m_last = e_g1 ? 1 : 0;
                end
                if (e_g0 && lock0) m_owner = 0;
                else if (e_g1 && lock1) m_owner = 1;
                else if (m_owner == 0 && (e_g0 || !req0)) m_owner = -1;
                else if (m_owner == 1 && (e_g1 || !req1)) m_owner = -1;
                if (req1 && !e_g1) m_age = (m_age < MAX_WAIT) ? m_age + 1 : MAX_WAIT;
                else m_age = 0;
            end
        end
    end

    task automatic next();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        req0 = 0; we0 = 0; lock0 = 0; addr0 = '0; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = '0; wdata1 = '0;
        next();
        chk_en = 1'b1;

        // Requests pending in reset are not granted
        req0 = 1; req1 = 1;
        @(negedge clk);
        check("rst_gnt0", gnt0, 0);
        check("rst_gnt1", gnt1, 0);
        check("rst_mem_en", mem_en, 0);
        next();
        rst = 0; req0 = 0; req1 = 0;

        // Port 0 alone reads 0x10
        next();
        req0 = 1; addr0 = 32'h10;
        @(negedge clk);
        check("p0rd_gnt0", gnt0, 1);
        check("p0rd_mem_en", mem_en, 1);
        check("p0rd_mem_addr", mem_addr, 32'h10);
        check("p0rd_mem_we", mem_we, 0);
        next();
        req0 = 0;
        @(negedge clk);
        check("p0rd_rvalid0", rvalid0, 1);
        check("p0rd_rdata0", rdata0, 32'hDEAD_BEEF);
        check("p0rd_rvalid1", rvalid1, 0);

        // Interleaved reads: port 0 at T, port 1 at T+1
        req0 = 1; addr0 = 32'h20;
        next();
        req0 = 0; req1 = 1; addr1 = 32'h30;
        @(negedge clk);
        check("il_rvalid0", rvalid0, 1);
        check("il_rdata0", rdata0, 32'hA500_0020);
        check("il_rvalid1_early", rvalid1, 0);
        next();
        req1 = 0;
        @(negedge clk);
        check("il_rvalid1", rvalid1, 1);
        check("il_rdata1", rdata1, 32'hA500_0030);
        check("il_rvalid0_clear", rvalid0, 0);

        // Port 1 write, then port 0 reads it back
        req1 = 1; we1 = 1; addr1 = 32'h40; wdata1 = 32'hCAFE_0040;
        @(negedge clk);
        check("wr_mem_we", mem_we, 1);
        check("wr_mem_wdata", mem_wdata, 32'hCAFE_0040);
        next();
        req1 = 0; we1 = 0; req0 = 1; addr0 = 32'h40;
        next();
        req0 = 0;
        @(negedge clk);
        check("wr_readback", rdata0, 32'hCAFE_0040);

        // Port 1 locks, port 0 held off, then reset mid-lock
        req1 = 1; lock1 = 1; addr1 = 32'h50;
        @(negedge clk);
        check("lk_gnt1_a", gnt1, 1);
        next();
        req0 = 1; addr0 = 32'h60;
        @(negedge clk);
        check("lk_gnt1_b", gnt1, 1);
        check("lk_gnt0_held", gnt0, 0);
        next();
        rst = 1;
        @(negedge clk);
        check("mrst_gnt0", gnt0, 0);
        check("mrst_gnt1", gnt1, 0);
        check("mrst_mem_en", mem_en, 0);
        check("mrst_rdata1", rdata1, 32'hA500_0050);
        next();
        rst = 0; lock1 = 0;

        // Continuous contention from a fresh reset
        for (int i = 0; i < 18; i++) begin
            logic exp1;
`ifdef ARB_RR_EN
            exp1 = (i % 2) == 1;
`else
            exp1 = (i == 8) || (i == 17);
`endif
            @(negedge clk);
            if (i == 0) check("mrst_rvalid1", rvalid1, 0);
            check($sformatf("cont_gnt1_%0d", i), gnt1, exp1);
            check($sformatf("cont_gnt0_%0d", i), gnt0, !exp1);
            next();
        end
        req0 = 0; req1 = 0;
        next();

        // Port 1 locked write burst: three locked grants then release
        req1 = 1; we1 = 1; lock1 = 1; addr1 = 32'h70; wdata1 = 32'h1111_0070;
        @(negedge clk);
        check("burst_gnt1_0", gnt1, 1);
        next();
        req0 = 1; addr0 = 32'h80;
        for (int k = 1; k < 4; k++) begin
            lock1 = (k < 3);
            addr1 = 32'h70 + 32'(k);
            wdata1 = 32'h1111_0070 + 32'(k);
            @(negedge clk);
            check($sformatf("burst_gnt1_%0d", k), gnt1, 1);
            check($sformatf("burst_gnt0_%0d", k), gnt0, 0);
            next();
        end
        req1 = 0; we1 = 0; lock1 = 0;
        @(negedge clk);
        check("burst_release_gnt0", gnt0, 1);
        next();
        req0 = 0;
        next();
        next();

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares one synchronous single-port data RAM between two requesters: port 0 = processor data port (direction/write_data/mem_write path), port 1 = auxiliary master (video scanner / loader).
- Fixed priority to port 0 with an aging counter that guarantees port 1 forward progress.
- Lock handshake gives a requester exclusive ownership for multi-access sequences.
- Sits between processor top level and data memory; memory read latency is 1 cycle.

Parameters:
AW, 32, address width
DW, 32, data width
MAX_WAIT, 8, cycles port 1 may be refused before it gets priority (1..255)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
req0  in  1  port 0 access request
we0  in  1  port 0 write enable
lock0  in  1  port 0 holds ownership after this access
addr0  in  AW  port 0 address
wdata0  in  DW  port 0 write data
gnt0  out  1  port 0 access issued this cycle
rvalid0  out  1  port 0 read data valid
rdata0  out  DW  port 0 read data
req1, we1, lock1, addr1, wdata1, gnt1, rvalid1, rdata1  same as port 0, for port 1
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after read strobe

Behaviour:
- Reset (rst high at clk edge): state=IDLE, wait_cnt=0, rd_tag=none, rvalid0/1=0. While rst high, gnt0/1, mem_en, mem_we forced 0. A request pending during reset is dropped; the requester re-presents it.
- Requester rule: req/we/addr/wdata/lock held stable until the gnt cycle. gnt is combinational, one cycle per access. Back-to-back accesses allowed every cycle.
- States: IDLE, OWN0, OWN1.
- IDLE selection:
  - only req0 -> port 0;
  - only req1 -> port 1;
  - both -> port 0, unless wait_cnt==MAX_WAIT, then port 1.
- OWNx: only port x is granted; the other is held off. Leave to IDLE when port x is granted with lock=0, or when req_x=0 (lock released when idle).
- Transition: a grant with lock=1 -> OWNx next cycle.
- Mem side: mem_* mirrors the granted port in the same cycle. mem_en=gnt0|gnt1; mem_we=we of the granted port; otherwise mem_en=0 and mem_addr/mem_wdata=0.
- Read return: on a granted read, rd_tag<=port. Next cycle rvalidN=1 and rdataN=mem_rdata. rdataN is don't-care (0) when rvalidN=0. Writes produce no rvalid.
- Aging:
  - wait_cnt increments (saturating at MAX_WAIT) each cycle req1=1 and gnt1=0;
  - clears on gnt1 or req1=0;
  - saturation overrides priority only in IDLE; OWN0 lock still holds. While saturated, port 1 wins the first IDLE cycle.
- Simultaneous grant-and-lock-release by port x with the other port requesting: the other port can be granted next cycle (no dead cycle).

Optional Feature:
- Macro ARB_RR_EN.
- Defined: contention in IDLE resolved round-robin via a last_gnt flop (reset 1 so port 0 wins first); aging counter still present but redundant.
- Undefined: fixed priority plus aging as above.

Decomposition:
- Package mem_arb_pkg: typedef enum arb_state_t {IDLE, OWN0, OWN1}; typedef port_id_t (1 bit, PORT0=0, PORT1=1); default AW/DW constants.
- Sub-module arb_age_counter: saturating wait counter with inc/clr/sat outputs.
- Selection and mux logic stays in mem_arbiter.

Test Plan:
- Reset mid-lock: OWN1 held, rst=1 one cycle -> state IDLE; gnt0/gnt1/mem_en=0 during rst; rvalid1=0 next cycle.
- Port 0 alone reads addr 0x10, mem_rdata=0xDEADBEEF -> gnt0=1 cycle T, mem_en=1, mem_addr=0x10, mem_we=0; rvalid0=1, rdata0=0xDEADBEEF at T+1; rvalid1=0.
- Both request continuously, MAX_WAIT=8, fixed priority -> gnt0 for 8 cycles, gnt1 on cycle 9, wait_cnt=0 after; repeats every 9 cycles.
- Port 1 writes with lock1=1 three times, then lock1=0, while req0 held -> gnt1 on 4 consecutive cycles, gnt0=0 throughout, gnt0=1 the cycle after the lock1=0 grant.
- Interleaved reads: port 0 read at T, port 1 read at T+1 -> rvalid0 at T+1, rvalid1 at T+2, data routed correctly with no cross-talk.
- ARB_RR_EN defined, both request continuously -> grants alternate 0,1,0,1 starting with port 0.
